// File: rtl/scaler_pkg.sv
// Shared constants for the scaler family: default sizing, epoch width and the
// 33 MHz reference rate from which tick dividers are derived.
package scaler_pkg;

    localparam int unsigned NCHAN_DEF  = 12;
    localparam int unsigned WIDTH_DEF  = 16;
    localparam int unsigned PERIOD_DEF = 1000;
    localparam int unsigned EPOCH_W    = 16;
    localparam int unsigned CLK33_HZ   = 33333333;

    // Number of clk33 cycles per tick for a requested tick rate in Hz.
    function automatic int unsigned tick_div(input int unsigned rate_hz);
        return CLK33_HZ / rate_hz;
    endfunction

endpackage

// File: rtl/scaler_chan.sv
// One scaler channel: rising-edge detect, saturating live counter with
// overflow flag, and the snapshot holding register.
module scaler_chan
    import scaler_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             trig_i,
    input  logic             snap_i,
    output logic [WIDTH-1:0] held_o,
    output logic             ovf_o
);

    localparam logic [WIDTH-1:0] CntMax = {WIDTH{1'b1}};

    logic             prev_q;
    logic             edge_det;
    logic [WIDTH-1:0] live_q, live_d;
    logic             lovf_q, lovf_d;
    logic [WIDTH-1:0] held_q, held_d;
    logic             ovf_q, ovf_d;

    assign edge_det = trig_i & ~prev_q;

    always_comb begin
        live_d = live_q;
        lovf_d = lovf_q;
        held_d = held_q;
        ovf_d  = ovf_q;
        if (snap_i) begin
            held_d = live_q;
            ovf_d  = lovf_q;
            // An edge coincident with the boundary belongs to the new gate.
            live_d = edge_det ? WIDTH'(1) : '0;
            lovf_d = 1'b0;
        end else if (edge_det) begin
            if (live_q == CntMax) begin
                lovf_d = 1'b1;
            end else begin
                live_d = live_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // History starts high so a level already asserted at release is not an edge.
            prev_q <= 1'b1;
            live_q <= '0;
            lovf_q <= 1'b0;
            held_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            prev_q <= trig_i;
            live_q <= live_d;
            lovf_q <= lovf_d;
            held_q <= held_d;
            ovf_q  <= ovf_d;
        end
    end

    assign held_o = held_q;
    assign ovf_o  = ovf_q;

endmodule

// File: rtl/scaler_gate_bank.sv
// Gated scaler bank: counts trigger edges per channel over PERIOD kHz ticks,
// snapshots at each gate end with no dead time, and serves a registered readout.
module scaler_gate_bank
    import scaler_pkg::*;
#(
    parameter int unsigned NCHAN  = NCHAN_DEF,
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned PERIOD = PERIOD_DEF,
    parameter int unsigned AW     = 4
) (
    input  logic               clk33_i,
    input  logic               rst_i,
    input  logic               khz_clk_i,
    input  logic [NCHAN-1:0]   trig_i,
    input  logic [AW-1:0]      rd_addr_i,
    output logic [WIDTH-1:0]   rd_data_o,
    output logic [NCHAN-1:0]   ovf_o,
    output logic [EPOCH_W-1:0] epoch_o,
    output logic               valid_o,
    input  logic               ack_i
);

    localparam int unsigned GW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [GW-1:0] GateLast = GW'(PERIOD - 1);

    logic [GW-1:0]      gate_q, gate_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   rd_data_q, rd_data_d;
    logic               gate_end;

    logic [WIDTH-1:0]   held [NCHAN];
    logic [NCHAN-1:0]   ovf_w;

    assign gate_end = khz_clk_i && (gate_q == GateLast);

    for (genvar i = 0; i < NCHAN; i++) begin : g_chan
        scaler_chan #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clk_i (clk33_i),
            .rst_i (rst_i),
            .trig_i(trig_i[i]),
            .snap_i(gate_end),
            .held_o(held[i]),
            .ovf_o (ovf_w[i])
        );
    end

    always_comb begin
        gate_d  = gate_q;
        epoch_d = epoch_q;
        valid_d = valid_q;
        if (khz_clk_i) begin
            gate_d = gate_end ? '0 : gate_q + 1'b1;
        end
        // Gate end takes priority over a coincident acknowledge.
        if (gate_end) begin
            epoch_d = epoch_q + 1'b1;
            valid_d = 1'b1;
        end else if (ack_i) begin
            valid_d = 1'b0;
        end
    end

    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < NCHAN; i++) begin
            if (rd_addr_i == AW'(i)) begin
                rd_data_d = held[i];
            end
        end
    end

    always_ff @(posedge clk33_i or posedge rst_i) begin
        if (rst_i) begin
            gate_q    <= '0;
            epoch_q   <= '0;
            valid_q   <= 1'b0;
            rd_data_q <= '0;
        end else begin
            gate_q    <= gate_d;
            epoch_q   <= epoch_d;
            valid_q   <= valid_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;
    assign ovf_o     = ovf_w;
    assign epoch_o   = epoch_q;
    assign valid_o   = valid_q;

endmodule

// File: tb/tb_scaler_gate_bank.sv
// Directed bench for scaler_gate_bank with a short gate (PERIOD=4) and narrow
// counters (WIDTH=4) so saturation is reachable quickly.
module tb_scaler_gate_bank;

    localparam int unsigned NCHAN  = 12;
    localparam int unsigned WIDTH  = 4;
    localparam int unsigned PERIOD = 4;
    localparam int unsigned AW     = 4;

    logic             clk;
    logic             rst;
    logic             khz;
    logic [NCHAN-1:0] trig;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic [NCHAN-1:0] ovf;
    logic [15:0]      epoch;
    logic             valid;
    logic             ack;

    int checks   = 0;
    int failures = 0;

    scaler_gate_bank #(
        .NCHAN (NCHAN),
        .WIDTH (WIDTH),
        .PERIOD(PERIOD),
        .AW    (AW)
    ) dut (
        .clk33_i  (clk),
        .rst_i    (rst),
        .khz_clk_i(khz),
        .trig_i   (trig),
        .rd_addr_i(rd_addr),
        .rd_data_o(rd_data),
        .ovf_o    (ovf),
        .epoch_o  (epoch),
        .valid_o  (valid),
        .ack_i    (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // All stimulus changes on the falling edge; one call = one rising edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic tick();
        khz = 1'b1;
        cyc();
        khz = 1'b0;
    endtask

    task automatic pulses(input int ch, input int n);
        for (int k = 0; k < n; k++) begin
            trig[ch] = 1'b1;
            cyc();
            trig[ch] = 1'b0;
            cyc();
        end
    endtask

    task automatic rd(input int addr, input string tag, input logic [31:0] exp);
        rd_addr = AW'(addr);
        cyc();
        chk(tag, 32'(rd_data), exp);
    endtask

    initial begin
        rst = 1'b1;
        khz = 1'b0;
        trig = '0;
        rd_addr = '0;
        ack = 1'b0;
        cyc();
        cyc();
        chk("rst_valid", 32'(valid), 0);
        chk("rst_epoch", 32'(epoch), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_ovf", 32'(ovf), 0);
        rst = 1'b0;
        cyc();

        // Basic count: 7 edges on ch0, 3 on ch5, one full gate.
        pulses(0, 7);
        pulses(5, 3);
        tick(); tick(); tick();
        chk("basic_valid_pre", 32'(valid), 0);
        tick();
        chk("basic_valid", 32'(valid), 1);
        chk("basic_epoch", 32'(epoch), 1);
        chk("basic_ovf", 32'(ovf), 0);
        rd(0, "basic_held0", 7);
        rd_addr = AW'(5);
        #1;
        chk("rd_latency_old", 32'(rd_data), 7);
        cyc();
        chk("basic_held5", 32'(rd_data), 3);
        rd(1, "basic_held1", 0);

        // Handshake: ack clears, ack while clear is harmless.
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        chk("ack_clear", 32'(valid), 0);
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        chk("ack_idle", 32'(valid), 0);
        chk("ack_idle_epoch", 32'(epoch), 1);

        // Gate 2: 4 edges on ch3, then a ch2 edge coincident with gate end.
        pulses(3, 4);
        tick(); tick(); tick();
        trig[2] = 1'b1;
        khz = 1'b1;
        cyc();
        khz = 1'b0;
        trig[2] = 1'b0;
        chk("coinc_valid", 32'(valid), 1);
        chk("coinc_epoch", 32'(epoch), 2);
        rd(2, "coinc_held2_excl", 0);
        rd(3, "readout_held3", 4);
        rd(13, "readout_oob", 0);

        // Gate 3: ack coincident with gate end; carried ch2 edge must appear.
        tick(); tick(); tick();
        khz = 1'b1;
        ack = 1'b1;
        cyc();
        khz = 1'b0;
        ack = 1'b0;
        chk("ack_gate_valid", 32'(valid), 1);
        chk("ack_gate_epoch", 32'(epoch), 3);
        rd(2, "coinc_held2_next", 1);
        rd(3, "gate3_held3", 0);
        rd(0, "gate3_held0", 0);

        // Saturation: 20 edges on ch7 in one gate, then 2 in the next.
        pulses(7, 20);
        tick(); tick(); tick(); tick();
        chk("sat_epoch", 32'(epoch), 4);
        chk("sat_ovf", 32'(ovf), 32'h080);
        rd(7, "sat_held7", 15);
        pulses(7, 2);
        tick(); tick(); tick(); tick();
        chk("unsat_ovf", 32'(ovf), 0);
        rd(7, "unsat_held7", 2);
        chk("unsat_epoch", 32'(epoch), 5);

        // Reset mid-gate with ch9 held high across release.
        tick(); tick();
        pulses(4, 5);
        trig[9] = 1'b1;
        cyc();
        chk("pre_rst_valid", 32'(valid), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(valid), 0);
        chk("mid_rst_epoch", 32'(epoch), 0);
        chk("mid_rst_rd_data", 32'(rd_data), 0);
        chk("mid_rst_ovf", 32'(ovf), 0);
        cyc();
        rst = 1'b0;
        cyc();
        tick(); tick(); tick();
        chk("post_rst_valid_pre", 32'(valid), 0);
        chk("post_rst_epoch_pre", 32'(epoch), 0);
        tick();
        chk("post_rst_valid", 32'(valid), 1);
        chk("post_rst_epoch", 32'(epoch), 1);
        rd(9, "post_rst_held9", 0);
        rd(4, "post_rst_held4", 0);
        trig[9] = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
